led_p2s_sched: RTL and testbench

Scheduler and arbiter in front of the 16-bit parallel-to-serial LED shifter (`P2S16b`). It takes display-update requests from two independent requesters and grants them round-robin. For each grant it loads the shifter with a one-cycle start pulse, waits for the shifter's finish, then drives the LED latch pulse. An optional periodic refresh re-sends the last displayed value. A shift-phase timeout guards against a hung shifter.

---
 rtl/led_p2s_sched.sv | 130 +++++++++++++
 tb/tb_led_p2s_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/led_p2s_sched.sv
// Round-robin scheduler in front of a 16-bit P2S LED shifter: grants two requesters,
// strobes the shifter, waits for finish (with timeout), pulses the latch, optionally refreshes.
module led_p2s_sched #(
  parameter int TIMEOUT   = 64,
  parameter int LATCH_CYC = 2,
  parameter int REFRESH   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        p2s_start,
  output logic [15:0] p2s_data,
  input  logic        p2s_finish,
  output logic        led_latch,
  output logic        busy,
  output logic        err,
  output logic [15:0] shown
);

  localparam int TW = $clog2((TIMEOUT   > 2) ? TIMEOUT   : 2);
  localparam int LW = $clog2((LATCH_CYC > 2) ? LATCH_CYC : 2);
  localparam int IW = $clog2((REFRESH   > 2) ? REFRESH   : 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t      state_q;
  logic        ack0_q, ack1_q, start_q, latch_q, busy_q, err_q;
  logic        last_grant_q;
  logic [15:0] p2s_data_q, shown_q;
  logic [TW-1:0] shift_cnt_q;
  logic [LW-1:0] latch_cnt_q;
  logic [IW-1:0] idle_cnt_q;

  logic grant1_d;
  logic refresh_due_d;

  // On a tie, grant whichever requester was not served last.
  always_comb begin
    grant1_d      = req1 && (!req0 || !last_grant_q);
    refresh_due_d = (REFRESH != 0) && (idle_cnt_q == IW'(REFRESH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      start_q      <= 1'b0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      p2s_data_q   <= '0;
      shown_q      <= '0;
      shift_cnt_q  <= '0;
      latch_cnt_q  <= '0;
      idle_cnt_q   <= '0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            last_grant_q <= grant1_d;
            p2s_data_q   <= grant1_d ? data1 : data0;
            ack0_q       <= !grant1_d;
            ack1_q       <= grant1_d;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
            idle_cnt_q   <= '0;
            state_q      <= S_LOAD;
          end else if (refresh_due_d) begin
            p2s_data_q <= shown_q;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= S_LOAD;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_q <= idle_cnt_q + IW'(1);
          end
        end
        S_LOAD: begin
          shift_cnt_q <= '0;
          state_q     <= S_SHIFT;
        end
        S_SHIFT: begin
          // A finish arriving on the timeout cycle still counts as success.
          if (p2s_finish) begin
            latch_q     <= 1'b1;
            latch_cnt_q <= '0;
            state_q     <= S_LATCH;
          end else if (shift_cnt_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            shift_cnt_q <= shift_cnt_q + TW'(1);
          end
        end
        S_LATCH: begin
          if (latch_cnt_q == LW'(LATCH_CYC - 1)) begin
            latch_q <= 1'b0;
            shown_q <= p2s_data_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            latch_cnt_q <= latch_cnt_q + LW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign p2s_start = start_q;
  assign p2s_data  = p2s_data_q;
  assign led_latch = latch_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign shown     = shown_q;

endmodule

// File: tb/tb_led_p2s_sched.sv
// Scoreboard bench for led_p2s_sched: stimulus pushes expected starts/latches, a monitor pops them.
module tb_led_p2s_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        ack0, ack1, p2s_start, led_latch, busy, err;
  logic [15:0] p2s_data, shown;
  logic        p2s_finish = 1'b0;

  int checks = 0;
  int failures = 0;
  int fin_delay = 17;  // 0 means the shifter never answers

  typedef struct packed {logic a0; logic a1; logic [15:0] d;} start_t;
  start_t      exp_start[$];
  logic [15:0] exp_shown[$];

  led_p2s_sched #(.TIMEOUT(64), .LATCH_CYC(2), .REFRESH(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .p2s_start(p2s_start), .p2s_data(p2s_data),
    .p2s_finish(p2s_finish), .led_latch(led_latch), .busy(busy), .err(err), .shown(shown)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("PASS %s value=%h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic push_start(input logic a0, input logic a1, input logic [15:0] d);
    start_t e;
    e.a0 = a0; e.a1 = a1; e.d = d;
    exp_start.push_back(e);
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(ack0 || ack1) && n < 200);
    if (!(ack0 || ack1)) timeout_fail("wait_ack");
  endtask

  task automatic wait_busy_low();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    if (busy) timeout_fail("wait_busy_low");
  endtask

  task automatic count_to_start(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!p2s_start && n < 50);
    if (!p2s_start) timeout_fail("wait_start");
  endtask

  // Shifter model: one-cycle finish a fixed delay after each start.
  initial begin
    forever begin
      @(negedge clk);
      if (p2s_start && !rst && fin_delay != 0) begin
        repeat (fin_delay - 1) @(negedge clk);
        p2s_finish = 1'b1;
        @(negedge clk);
        p2s_finish = 1'b0;
      end
    end
  end

  // Monitor: each start and each completed latch pulse is matched against the queues.
  initial begin
    int     lat_len = 0;
    start_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat_len = 0;
      end else begin
        if (p2s_start) begin
          if (exp_start.size() == 0) timeout_fail("unexpected_start");
          else begin
            e = exp_start.pop_front();
            check("start_txn", {14'b0, ack0, ack1, p2s_data}, {14'b0, e.a0, e.a1, e.d});
          end
        end else if (ack0 || ack1) begin
          check("ack_without_start", {30'b0, ack0, ack1}, 32'd0);
        end
        if (led_latch) lat_len++;
        else if (lat_len != 0) begin
          check("latch_len", lat_len, 32'd2);
          if (exp_shown.size() == 0) timeout_fail("unexpected_latch");
          else check("shown_after_latch", {16'b0, shown}, {16'b0, exp_shown.pop_front()});
          lat_len = 0;
        end
      end
    end
  end

  initial begin
    int  n;
    logic seen;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {26'b0, ack0, ack1, p2s_start, led_latch, busy, err}, 32'd0);
    check("reset_data", {p2s_data, shown}, 32'd0);
    rst = 1'b0;

    // Single request
    req0 = 1'b1; data0 = 16'h9571;
    push_start(1'b1, 1'b0, 16'h9571); exp_shown.push_back(16'h9571);
    wait_ack();
    check("ack0_with_start", {30'b0, ack0, p2s_start}, 32'd3);
    req0 = 1'b0;
    wait_busy_low();
    check("single_shown", {16'b0, shown}, 32'h9571);

    // Round-robin: last grant was 0, so the tie order is 1,0,1,0
    req0 = 1'b1; data0 = 16'hF0F0; req1 = 1'b1; data1 = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      push_start(i[0], !i[0], i[0] ? 16'hF0F0 : 16'h0F0F);
      exp_shown.push_back(i[0] ? 16'hF0F0 : 16'h0F0F);
    end
    for (int i = 0; i < 4; i++) wait_ack();
    req0 = 1'b0; req1 = 1'b0;
    wait_busy_low();

    // Request raised while busy
    req0 = 1'b1; data0 = 16'h5A5A;
    push_start(1'b1, 1'b0, 16'h5A5A); exp_shown.push_back(16'h5A5A);
    wait_ack();
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    req1 = 1'b1; data1 = 16'h1234;
    push_start(1'b0, 1'b1, 16'h1234); exp_shown.push_back(16'h1234);
    n = 0; seen = 1'b0;
    do begin @(negedge clk); n++; if (ack1) seen = 1'b1; end while (busy && n < 200);
    check("no_ack1_while_busy", {30'b0, seen, busy}, 32'd0);
    @(negedge clk);
    check("ack1_after_idle", {31'b0, ack1}, 32'd1);
    req1 = 1'b0;
    wait_busy_low();

    // Refresh of 1234 every 8 idle cycles, twice
    for (int r = 0; r < 2; r++) begin
      push_start(1'b0, 1'b0, 16'h1234); exp_shown.push_back(16'h1234);
      count_to_start(n);
      check("refresh_interval", n, 32'd8);
      wait_busy_low();
    end
    // Request sampled on the cycle the refresh falls due
    repeat (7) @(negedge clk);
    req1 = 1'b1; data1 = 16'h7777;
    push_start(1'b0, 1'b1, 16'h7777); exp_shown.push_back(16'h7777);
    @(negedge clk);
    check("req_beats_refresh", {30'b0, p2s_start, ack1}, 32'd3);
    req1 = 1'b0;
    wait_busy_low();

    // Timeout with a hung shifter
    fin_delay = 0;
    req0 = 1'b1; data0 = 16'h0BAD;
    push_start(1'b1, 1'b0, 16'h0BAD);
    wait_ack();
    req0 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 200);
    check("timeout_shift_cycles", n - 1, 32'd64);
    check("timeout_state", {15'b0, err, busy, shown}, {15'b0, 1'b1, 1'b0, 16'h7777});
    fin_delay = 17;
    req1 = 1'b1; data1 = 16'h3C3C;
    push_start(1'b0, 1'b1, 16'h3C3C); exp_shown.push_back(16'h3C3C);
    wait_ack();
    req1 = 1'b0;
    wait_busy_low();
    check("err_sticky", {31'b0, err}, 32'd1);

    // Reset in the middle of SHIFT
    fin_delay = 0;
    req0 = 1'b1; data0 = 16'h5555;
    push_start(1'b1, 1'b0, 16'h5555);
    wait_ack();
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ctrl", {26'b0, ack0, ack1, p2s_start, led_latch, busy, err}, 32'd0);
    check("rst_data", {p2s_data, shown}, 32'd0);
    fin_delay = 17;
    req0 = 1'b1; data0 = 16'h1111; req1 = 1'b1; data1 = 16'h2222;
    push_start(1'b1, 1'b0, 16'h1111); exp_shown.push_back(16'h1111);
    push_start(1'b0, 1'b1, 16'h2222); exp_shown.push_back(16'h2222);
    wait_ack();
    check("tie_after_reset", {30'b0, ack0, ack1}, 32'd2);
    req0 = 1'b0;
    wait_ack();
    req1 = 1'b0;
    wait_busy_low();
    check("queues_drained", exp_start.size() + exp_shown.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
